cmd_arbiter: RTL and testbench
==============================

# cmd_arbiter

Arbitrates stopwatch commands from two requesters, the debounced push-button path and the UART RX byte stream, onto the single command port of the run/stop/clear control FSM. It latches one-cycle button pulses, decodes ASCII command bytes, grants one command at a time with round-robin fairness between sources, and enforces a hold-off gap after each grant. It also owns the display-mode level. The block sits between the button debouncers / UART receiver and the counter control unit.

## Interface
- HOLDOFF_CYC, 100_000: idle cycles after each grant before the next grant (1 ms at 100 MHz); legal range ≥ 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- btn_run_stop  in  1  one-cycle pulse from button edge detector
- btn_clear  in  1  one-cycle pulse
- btn_mode  in  1  one-cycle pulse
- uart_valid  in  1  RX byte valid
- uart_data  in  8  RX byte
- uart_ready  out  1  arbiter accepts byte this cycle
- o_run_stop  out  1  one-cycle command pulse to control FSM
- o_clear  out  1  one-cycle command pulse
- o_mode  out  1  display-mode level
- o_src  out  1  source of last grant: 0 = button, 1 = UART
- o_drop_cnt  out  8  saturating count of rejected UART bytes

## Operation
- **Button pending flags** (btn_rs_p, btn_clr_p, btn_mode_p):
  - An input pulse sets its flag.
  - A repeat pulse while the flag is set is merged, not counted.
  - A flag clears only when granted. If a new pulse arrives in the same cycle as the clear, the flag stays set.
- **UART path:**
  - 1-entry command register uart_cmd (CMD_NONE when empty); uart_ready = (uart_cmd == CMD_NONE).
  - A byte is accepted on uart_valid & uart_ready.
  - Decode: 'R'/'r' → CMD_RUN_STOP, 'C'/'c' → CMD_CLEAR, 'M'/'m' → CMD_MODE.
  - Any other byte is consumed and o_drop_cnt increments, saturating at 255. No command is stored.
- **Within-source priority (buttons):** clear > run_stop > mode.
- **Round-robin:** rr_last holds the source of the last grant, reset 0. When both sources have work pending, the source ≠ rr_last wins. Each grant updates rr_last and o_src.
- **FSM states:** IDLE, GRANT, HOLD.
  - IDLE: if any work is pending, latch the selected command and go to GRANT; otherwise stay in IDLE.
  - GRANT (exactly 1 cycle):
    - Assert the pulse for the selected command: o_run_stop or o_clear, or toggle o_mode.
    - Clear the granted flag, or empty uart_cmd.
    - Go to HOLD.
  - HOLD: the hold counter runs from 0 to HOLDOFF_CYC−1, then the FSM returns to IDLE.
- **Input capture:** button pulses and UART bytes are captured in every state. Nothing is lost during HOLD.
- **Reset values (asynchronous):** state IDLE, all flags 0, uart_cmd CMD_NONE, rr_last 0, o_src 0, o_run_stop 0, o_clear 0, o_mode 0, o_drop_cnt 0, uart_ready 1 (combinational from uart_cmd). Reset mid-HOLD or mid-GRANT discards all pending work.

## Timing
- Input pulse at cycle t with FSM idle:
  - flag set at t+1
  - FSM in GRANT at t+2
  - o_run_stop / o_clear high during t+2 only
  - o_mode toggles at the edge ending t+2, visible from t+3
- UART byte accepted at t: same latency as a button pulse (grant at t+2).
- Back-to-back grants are spaced HOLDOFF_CYC+2 cycles apart.
- o_run_stop and o_clear are never high in the same cycle. At most one command is issued per GRANT.
- Hold counter width: $clog2(HOLDOFF_CYC+1).

## Structure
- **Shared package cmd_pkg:**
  - 2-bit command codes CMD_NONE=0, CMD_RUN_STOP=1, CMD_CLEAR=2, CMD_MODE=3
  - ASCII constants 0x52/0x72, 0x43/0x63, 0x4D/0x6D
  - FSM state encoding
  - source codes SRC_BTN=0, SRC_UART=1
- **Sub-module ascii_cmd_decode:** combinational byte → command code plus valid flag. The FSM, flags and counters stay in cmd_arbiter.

## Test plan
- **Reset and single button:** after reset, check all outputs at their reset values and uart_ready = 1. Pulse btn_run_stop at t → o_run_stop high only at t+2, o_src = 0.
- **Simultaneous buttons:** pulse btn_clear and btn_run_stop in the same cycle with HOLDOFF_CYC = 4 → o_clear at t+2, o_run_stop at t+8. No pulse is lost.
- **Round-robin:** with a UART 'r' and btn_mode both pending, and rr_last = 0 → the UART command is granted first (o_run_stop, o_src = 1). o_mode toggles 0→1 on the following grant, with o_src = 0.
- **Backpressure and drop:**
  - Send 'C' during HOLD → uart_ready goes 0 until that grant.
  - Send 'x' → consumed, o_drop_cnt = 1, no pulse.
  - Send 300 invalid bytes → o_drop_cnt stays at 255.
- **Merge and collision:**
  - 3 btn_mode pulses during HOLD → exactly one toggle.
  - A btn_clear pulse in the same cycle as its own GRANT → a second o_clear one period later.
- **Reset mid-operation:** assert reset in HOLD with a UART command and two flags pending → after release, no pulses appear, o_mode = 0, and the FSM is in IDLE.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the stopwatch command arbiter: command codes,
// accepted ASCII bytes, arbiter FSM states and grant-source codes.
package cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_RUN_STOP = 2'd1,
    CMD_CLEAR    = 2'd2,
    CMD_MODE     = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic SRC_BTN  = 1'b0;
  localparam logic SRC_UART = 1'b1;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;

endpackage

// File: rtl/ascii_cmd_decode.sv
// Maps one received UART byte to a stopwatch command code; upper and
// lower case letters are equivalent, anything else decodes as CMD_NONE.
module ascii_cmd_decode
  import cmd_pkg::*;
(
  input  logic [7:0] data,
  output logic [1:0] cmd,
  output logic       valid
);

  // Byte-to-command lookup.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    cmd = CMD_NONE;
    case (data)
      ASCII_R_UP, ASCII_R_LO: cmd = CMD_RUN_STOP;
      ASCII_C_UP, ASCII_C_LO: cmd = CMD_CLEAR;
      ASCII_M_UP, ASCII_M_LO: cmd = CMD_MODE;
      default:                cmd = CMD_NONE;
    endcase
    valid = (cmd != CMD_NONE);
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Merges push-button pulses and UART command bytes onto the single
// command port of the stopwatch control FSM. One command is granted at a
// time, sources alternate when both have work, and every grant is followed
// by a hold-off gap. Also owns the display-mode level.
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int HOLDOFF_CYC = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  output logic       uart_ready,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_src,
  output logic [7:0] o_drop_cnt
);

  localparam int                CNT_W     = $clog2(HOLDOFF_CYC + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

  state_e           state;
  cmd_e             sel_cmd;
  logic             sel_src;
  logic             rr_last;
  logic [CNT_W-1:0] hold_cnt;

  logic btn_rs_p, btn_clr_p, btn_mode_p;
  cmd_e uart_cmd;

  logic [1:0] dec_cmd;
  logic       dec_valid;
  logic       uart_accept;

  cmd_e btn_cmd;
  cmd_e pick_cmd;
  logic pick_src;
  logic btn_any, uart_any;

  logic in_grant;
  logic clr_rs_grant, clr_clr_grant, clr_mode_grant, clr_uart_grant;

  ascii_cmd_decode u_decode (
    .data  (uart_data),
    .cmd   (dec_cmd),
    .valid (dec_valid)
  );

  assign uart_ready  = (uart_cmd == CMD_NONE);
  assign uart_accept = uart_valid & uart_ready;

  // The granted request is retired at the end of the single GRANT cycle.
  assign in_grant       = (state == ST_GRANT);
  assign clr_rs_grant   = in_grant && (sel_src == SRC_BTN)  && (sel_cmd == CMD_RUN_STOP);
  assign clr_clr_grant  = in_grant && (sel_src == SRC_BTN)  && (sel_cmd == CMD_CLEAR);
  assign clr_mode_grant = in_grant && (sel_src == SRC_BTN)  && (sel_cmd == CMD_MODE);
  assign clr_uart_grant = in_grant && (sel_src == SRC_UART);

  // Pick the next command: clear > run_stop > mode among buttons, and the
  // source other than the last winner when both sources have work.
  always_comb begin
    btn_cmd = CMD_NONE;
    if (btn_clr_p)       btn_cmd = CMD_CLEAR;
    else if (btn_rs_p)   btn_cmd = CMD_RUN_STOP;
    else if (btn_mode_p) btn_cmd = CMD_MODE;

    btn_any  = (btn_cmd != CMD_NONE);
    uart_any = (uart_cmd != CMD_NONE);

    pick_src = SRC_BTN;
    pick_cmd = btn_cmd;
    if (uart_any && (!btn_any || rr_last == SRC_BTN)) begin
      pick_src = SRC_UART;
      pick_cmd = uart_cmd;
    end
  end

  // Button pending flags: a pulse sets, repeats merge, a grant clears, and a
  // pulse coinciding with its own grant keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_rs_p   <= 1'b0;
      btn_clr_p  <= 1'b0;
      btn_mode_p <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of block order.
      btn_rs_p   <= btn_run_stop | (btn_rs_p   & ~clr_rs_grant);
      btn_clr_p  <= btn_clear    | (btn_clr_p  & ~clr_clr_grant);
      btn_mode_p <= btn_mode     | (btn_mode_p & ~clr_mode_grant);
    end
  end

  // One-entry UART command register plus saturating count of bad bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_cmd   <= CMD_NONE;
      o_drop_cnt <= 8'd0;
    end else begin
      if (clr_uart_grant) begin
        uart_cmd <= CMD_NONE;
      end else if (uart_accept && dec_valid) begin
        uart_cmd <= cmd_e'(dec_cmd);
      end
      if (uart_accept && !dec_valid && (o_drop_cnt != 8'hFF)) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

  // Grant sequencer: IDLE latches a command, GRANT issues it for one cycle,
  // HOLD waits out the hold-off gap. Command outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_cmd    <= CMD_NONE;
      sel_src    <= SRC_BTN;
      rr_last    <= SRC_BTN;
      hold_cnt   <= '0;
      o_src      <= SRC_BTN;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      o_mode     <= 1'b0;
    end else begin
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_any || uart_any) begin
            sel_cmd    <= pick_cmd;
            sel_src    <= pick_src;
            rr_last    <= pick_src;
            o_src      <= pick_src;
            o_run_stop <= (pick_cmd == CMD_RUN_STOP);
            o_clear    <= (pick_cmd == CMD_CLEAR);
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (sel_cmd == CMD_MODE) begin
            o_mode <= ~o_mode;
          end
          hold_cnt <= '0;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed scenarios followed by a
// randomized run against a cycle-stamped reference model.
module tb_cmd_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_mode = 1'b0;
  logic       uart_valid = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       uart_ready;
  logic       o_run_stop;
  logic       o_clear;
  logic       o_mode;
  logic       o_src;
  logic [7:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] valid_bytes [6] = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D};

  cmd_arbiter #(.HOLDOFF_CYC(HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .btn_mode     (btn_mode),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .uart_ready   (uart_ready),
    .o_run_stop   (o_run_stop),
    .o_clear      (o_clear),
    .o_mode       (o_mode),
    .o_src        (o_src),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // 0 none, 1 run_stop, 2 clear, 3 mode
  function automatic int model_decode(input logic [7:0] b);
    case (b)
      8'h52, 8'h72: return 1;
      8'h43, 8'h63: return 2;
      8'h4D, 8'h6D: return 3;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [7:0] rand_invalid();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (model_decode(b) != 0) b = 8'h00;
    return b;
  endfunction

  // Present inputs for one cycle, land on the next falling edge.
  task automatic tick(input bit rs, input bit clr, input bit md,
                      input bit uv, input logic [7:0] ud);
    btn_run_stop = rs;
    btn_clear    = clr;
    btn_mode     = md;
    uart_valid   = uv;
    uart_data    = ud;
    @(negedge clk);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_mode     = 1'b0;
    uart_valid   = 1'b0;
    uart_data    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 8'h00);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_run_stop !== 1'b0) begin errors++; $display("FAIL reset_run_stop got %0b want 0", o_run_stop); end
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %0b want 0", o_clear); end
    checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %0b want 0", o_mode); end
    checks++; if (o_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", o_src); end
    checks++; if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", o_drop_cnt); end
    checks++; if (uart_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", uart_ready); end
    tick(1, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (o_run_stop !== (k == 2)) begin errors++; $display("FAIL single_rs t+%0d got %0b want %0b", k, o_run_stop, k == 2); end
      if (k == 2) begin
        checks++;
        if (o_src !== 1'b0) begin errors++; $display("FAIL single_src got %0b want 0", o_src); end
      end
      idle(1);
    end
    idle(8);
  endtask

  task automatic test_simultaneous();
    tick(1, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (o_clear !== (k == 2)) begin errors++; $display("FAIL simul_clear t+%0d got %0b want %0b", k, o_clear, k == 2); end
      checks++;
      if (o_run_stop !== (k == 8)) begin errors++; $display("FAIL simul_rs t+%0d got %0b want %0b", k, o_run_stop, k == 8); end
      idle(1);
    end
    idle(4);
  endtask

  task automatic test_round_robin();
    tick(0, 0, 1, 1, 8'h72);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (o_run_stop !== (k == 2)) begin errors++; $display("FAIL rr_rs t+%0d got %0b want %0b", k, o_run_stop, k == 2); end
      checks++;
      if (o_src !== (k >= 2 && k < 8)) begin errors++; $display("FAIL rr_src t+%0d got %0b want %0b", k, o_src, (k >= 2 && k < 8)); end
      checks++;
      if (o_mode !== (k >= 9)) begin errors++; $display("FAIL rr_mode t+%0d got %0b want %0b", k, o_mode, k >= 9); end
      idle(1);
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k <= 10; k++) begin
      int c;
      tick(k == 0, 0, 0, k == 3, (k == 3) ? 8'h43 : 8'h00);
      c = k + 1;
      checks++;
      if (uart_ready !== !(c >= 4 && c <= 8)) begin errors++; $display("FAIL bp_ready t+%0d got %0b want %0b", c, uart_ready, !(c >= 4 && c <= 8)); end
      checks++;
      if (o_clear !== (c == 8)) begin errors++; $display("FAIL bp_clear t+%0d got %0b want %0b", c, o_clear, c == 8); end
      checks++;
      if (o_run_stop !== (c == 2)) begin errors++; $display("FAIL bp_rs t+%0d got %0b want %0b", c, o_run_stop, c == 2); end
      if (c == 8) begin
        checks++;
        if (o_src !== 1'b1) begin errors++; $display("FAIL bp_src got %0b want 1", o_src); end
      end
    end
    idle(6);
    tick(0, 0, 0, 1, 8'h78);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({o_run_stop, o_clear, uart_ready} !== 3'b001) begin
        errors++; $display("FAIL drop_nopulse t+%0d got rs=%0b clr=%0b rdy=%0b want 0 0 1", k, o_run_stop, o_clear, uart_ready);
      end
      idle(1);
    end
    checks++;
    if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_one got %0d want 1", o_drop_cnt); end
    for (int i = 0; i < 253; i++) tick(0, 0, 0, 1, rand_invalid());
    checks++;
    if (o_drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254 got %0d want 254", o_drop_cnt); end
    for (int i = 0; i < 47; i++) tick(0, 0, 0, 1, rand_invalid());
    checks++;
    if (o_drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", o_drop_cnt); end
    idle(2);
  endtask

  task automatic test_merge();
    logic start_mode, prev;
    int toggles;
    start_mode = o_mode;
    prev = o_mode;
    toggles = 0;
    for (int k = 0; k < 20; k++) begin
      tick(k == 0, 0, (k >= 3 && k <= 5), 0, 8'h00);
      if (o_mode !== prev) toggles++;
      prev = o_mode;
    end
    checks++;
    if (toggles !== 1) begin errors++; $display("FAIL merge_toggles got %0d want 1", toggles); end
    checks++;
    if (o_mode !== ~start_mode) begin errors++; $display("FAIL merge_mode got %0b want %0b", o_mode, ~start_mode); end
    idle(4);
    for (int k = 0; k <= 12; k++) begin
      int c;
      tick(0, (k == 0 || k == 2), 0, 0, 8'h00);
      c = k + 1;
      checks++;
      if (o_clear !== (c == 2 || c == 8)) begin errors++; $display("FAIL collide_clear t+%0d got %0b want %0b", c, o_clear, (c == 2 || c == 8)); end
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 3; k++) begin
      tick(0, k == 3, (k == 0 || k == 3), k == 3, (k == 3) ? 8'h6D : 8'h00);
    end
    checks++;
    if (o_mode !== 1'b1) begin errors++; $display("FAIL rstmid_pre_mode got %0b want 1", o_mode); end
    checks++;
    if (uart_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre_ready got %0b want 0", uart_ready); end
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({o_run_stop, o_clear, o_mode, uart_ready} !== 4'b0001) begin
        errors++; $display("FAIL rstmid_quiet c%0d got rs=%0b clr=%0b mode=%0b rdy=%0b want 0 0 0 1", k, o_run_stop, o_clear, o_mode, uart_ready);
      end
      idle(1);
    end
    checks++;
    if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_drop got %0d want 0", o_drop_cnt); end
    tick(1, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (o_run_stop !== (k == 2)) begin errors++; $display("FAIL rstmid_idle t+%0d got %0b want %0b", k, o_run_stop, k == 2); end
      idle(1);
    end
    idle(6);
  endtask

  // Reference model tracks pending work and the cycle stamps at which the
  // arbiter may next choose and at which a chosen command is issued.
  task automatic test_random();
    bit p_rs, p_clr, p_mode, rr, m_src, m_mode;
    bit r_rs, r_clr, r_md, r_v, accept, any_btn;
    int u_cmd, m_drop, free_at, g_cyc, g_cmd, g_src, code;
    logic [7:0] r_d;
    apply_reset();
    p_rs = 0; p_clr = 0; p_mode = 0; rr = 0; m_src = 0; m_mode = 0;
    u_cmd = 0; m_drop = 0; free_at = 0; g_cyc = -1; g_cmd = 0; g_src = 0;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (o_run_stop !== (n == g_cyc && g_cmd == 1)) begin errors++; $display("FAIL rand_rs cyc %0d got %0b want %0b", n, o_run_stop, (n == g_cyc && g_cmd == 1)); end
      checks++;
      if (o_clear !== (n == g_cyc && g_cmd == 2)) begin errors++; $display("FAIL rand_clear cyc %0d got %0b want %0b", n, o_clear, (n == g_cyc && g_cmd == 2)); end
      checks++;
      if (o_mode !== m_mode) begin errors++; $display("FAIL rand_mode cyc %0d got %0b want %0b", n, o_mode, m_mode); end
      checks++;
      if (o_src !== m_src) begin errors++; $display("FAIL rand_src cyc %0d got %0b want %0b", n, o_src, m_src); end
      checks++;
      if (uart_ready !== (u_cmd == 0)) begin errors++; $display("FAIL rand_ready cyc %0d got %0b want %0b", n, uart_ready, u_cmd == 0); end
      checks++;
      if (o_drop_cnt !== m_drop[7:0]) begin errors++; $display("FAIL rand_drop cyc %0d got %0d want %0d", n, o_drop_cnt, m_drop); end

      r_rs  = ($urandom_range(0, 99) < 10);
      r_clr = ($urandom_range(0, 99) < 8);
      r_md  = ($urandom_range(0, 99) < 10);
      r_v   = ($urandom_range(0, 99) < 30);
      r_d   = $urandom_range(0, 1) ? valid_bytes[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      btn_run_stop = r_rs;
      btn_clear    = r_clr;
      btn_mode     = r_md;
      uart_valid   = r_v;
      uart_data    = r_d;

      accept = r_v && (u_cmd == 0);
      if (n == g_cyc) begin
        if (g_src == 1) u_cmd = 0;
        else if (g_cmd == 1) p_rs = 0;
        else if (g_cmd == 2) p_clr = 0;
        else p_mode = 0;
        if (g_cmd == 3) m_mode = ~m_mode;
      end
      any_btn = p_rs || p_clr || p_mode;
      if (n >= free_at && (any_btn || u_cmd != 0)) begin
        if (u_cmd != 0 && (!any_btn || rr == 0)) begin
          g_src = 1; g_cmd = u_cmd;
        end else begin
          g_src = 0; g_cmd = p_clr ? 2 : (p_rs ? 1 : 3);
        end
        g_cyc   = n + 1;
        free_at = n + HOLD + 2;
        rr      = g_src[0];
        m_src   = g_src[0];
      end
      p_rs   = p_rs   | r_rs;
      p_clr  = p_clr  | r_clr;
      p_mode = p_mode | r_md;
      if (accept) begin
        code = model_decode(r_d);
        if (code != 0) u_cmd = code;
        else if (m_drop < 255) m_drop++;
      end
      @(negedge clk);
    end
    btn_run_stop = 0; btn_clear = 0; btn_mode = 0; uart_valid = 0; uart_data = 8'h00;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_merge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
